// File: rtl/instr_encoder.sv
// Instruction encoder: packs instruction requests into 32-bit words, queues them in a
// 4-deep FIFO and streams them into instruction memory at consecutive byte addresses.
//
// state | meaning
// IDLE  | waiting for start_i; accepted requests queue but are not written
// ARMED | address loaded; moves to WRITE when a word is queued
// WRITE | presenting the FIFO head to memory until imem_ack_i

module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_class_i,
  input  logic [4:0]  req_rs_i,
  input  logic [4:0]  req_rt_i,
  input  logic [4:0]  req_rd_i,
  input  logic [5:0]  req_funct_i,
  input  logic [15:0] req_imm_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  input  logic        imem_ack_i,
  output logic [7:0]  count_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  occ;
  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;

  always_comb begin
    enc_word = 32'd0;
    case (req_class_i)
      4'd0:    enc_word = {6'd0, req_rs_i, req_rt_i, req_rd_i, 5'd0, req_funct_i};
      4'd1:    enc_word = {6'd8,  req_rs_i, req_rt_i, req_imm_i};
      4'd2:    enc_word = {6'd10, req_rs_i, req_rt_i, req_imm_i};
      4'd3:    enc_word = {6'd4,  req_rs_i, req_rt_i, req_imm_i};
      4'd4:    enc_word = {6'd43, req_rs_i, req_rt_i, req_imm_i};
      4'd5:    enc_word = {6'd35, req_rs_i, req_rt_i, req_imm_i};
      4'd6:    enc_word = {6'd5,  req_rs_i, req_rt_i, req_imm_i};
      4'd7:    enc_word = {6'd1,  req_rs_i, req_rt_i, req_imm_i};
      4'd8:    enc_word = {6'd7,  req_rs_i, req_rt_i, req_imm_i};
      default: enc_word = 32'd0;
    endcase
  end

  assign req_ready_o = (occ != 3'd4);
  assign accept      = req_valid_i & req_ready_o;
  assign legal       = (req_class_i <= 4'd8);
  assign push        = accept & legal;
  assign pop         = (state == WRITE) & imem_ack_i;
  assign busy_o      = (occ != 3'd0) | (state == WRITE);

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_o <= 1'b0;
    else if (accept && !legal) err_o <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      addr        <= 32'd0;
      count_o     <= 8'd0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= 32'd0;
      imem_data_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            addr    <= base_addr_i;
            count_o <= 8'd0;
            state   <= ARMED;
          end
        end
        ARMED: begin
          if (occ != 3'd0) begin
            imem_we_o   <= 1'b1;
            imem_addr_o <= addr;
            imem_data_o <= fifo_mem[rd_ptr];
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (imem_ack_i) begin
            imem_we_o <= 1'b0;
            addr      <= addr + 32'd4;
            if (count_o != 8'hFF) count_o <= count_o + 8'd1;
            state     <= ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, illegal classes,
// pre-start queueing and reset in the middle of a write.

module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = 32'd0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_class_i = 4'd0;
  logic [4:0]  req_rs_i = 5'd0;
  logic [4:0]  req_rt_i = 5'd0;
  logic [4:0]  req_rd_i = 5'd0;
  logic [5:0]  req_funct_i = 6'd0;
  logic [15:0] req_imm_i = 16'd0;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic        imem_ack_i = 1'b0;
  logic [7:0]  count_o;
  logic        err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] wr_q[$];

  instr_encoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_class_i(req_class_i),
    .req_rs_i(req_rs_i), .req_rt_i(req_rt_i), .req_rd_i(req_rd_i),
    .req_funct_i(req_funct_i), .req_imm_i(req_imm_i), .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o), .imem_ack_i(imem_ack_i),
    .count_o(count_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every completed memory write as {addr, data}.
  always @(posedge clk_i) begin
    if (rst_i && imem_we_o && imem_ack_i) wr_q.push_back({imem_addr_o, imem_data_o});
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    start_i = 1'b0;
    req_valid_i = 1'b0;
    imem_ack_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    wr_q.delete();
  endtask

  task automatic do_start(input logic [31:0] base);
    start_i = 1'b1;
    base_addr_i = base;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
    req_class_i = cls;
    req_rs_i = rs;
    req_rt_i = rt;
    req_rd_i = rd;
    req_funct_i = funct;
    req_imm_i = imm;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int budget = 60;
    while (wr_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (wr_q.size() != n) begin
      errors++;
      $display("FAIL %s write count: got %0d want %0d", name, wr_q.size(), n);
    end
  endtask

  task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d,
                             input string name);
    logic [63:0] got;
    got = (idx < wr_q.size()) ? wr_q[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
    checks++;
    if (got !== {a, d}) begin
      errors++;
      $display("FAIL %s write %0d: got addr=%h data=%h want addr=%h data=%h",
               name, idx, got[63:32], got[31:0], a, d);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #3;
    checks++;
    if ({imem_we_o, imem_addr_o, imem_data_o, count_o, err_o, busy_o} !== 75'd0) begin
      errors++;
      $display("FAIL reset outputs: got we=%b addr=%h data=%h cnt=%0d err=%b busy=%b want all 0",
               imem_we_o, imem_addr_o, imem_data_o, count_o, err_o, busy_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset ready: got %b want 1", req_ready_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    imem_ack_i = 1'b1;
    do_start(32'h100);
    send(4'd1, 5'd0, 5'd9, 5'd0, 6'd0, 16'h0005);
    checks++;
    if (imem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL latency edge N: got we=%b want 0", imem_we_o);
    end
    send(4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0000);
    checks++;
    if ({imem_we_o, imem_addr_o, imem_data_o} !== {1'b1, 32'h100, 32'h20090005}) begin
      errors++;
      $display("FAIL latency edge N+1: got we=%b addr=%h data=%h want 1 00000100 20090005",
               imem_we_o, imem_addr_o, imem_data_o);
    end
    send(4'd5, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004);
    send(4'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF);
    wait_writes(4, "single");
    check_write(0, 32'h100, 32'h20090005, "single");
    check_write(1, 32'h104, 32'h01095020, "single");
    check_write(2, 32'h108, 32'h8FA80004, "single");
    check_write(3, 32'h10C, 32'h1022FFFF, "single");
    checks++;
    if (count_o !== 8'd4 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single end: got count=%0d busy=%b want 4 0", count_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [64:0] snap;
    bit stable;
    int budget;
    do_reset();
    imem_ack_i = 1'b0;
    do_start(32'h200);
    for (int k = 1; k <= 4; k++) begin
      send(4'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'(k));
      if (k == 3) begin
        checks++;
        if (req_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL backpressure ready after 3: got %b want 1", req_ready_o);
        end
      end
    end
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL backpressure ready after 4: got %b want 0", req_ready_o);
    end
    req_imm_i = 16'd5;
    req_valid_i = 1'b1;
    snap = {imem_we_o, imem_addr_o, imem_data_o};
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({imem_we_o, imem_addr_o, imem_data_o} !== snap) stable = 1'b0;
    end
    checks++;
    if (!stable || snap !== {1'b1, 32'h200, 32'h20010001}) begin
      errors++;
      $display("FAIL backpressure stall: got we=%b addr=%h data=%h stable=%b want 1 00000200 20010001 1",
               imem_we_o, imem_addr_o, imem_data_o, stable);
    end
    imem_ack_i = 1'b1;
    budget = 20;
    while (!req_ready_o && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    req_valid_i = 1'b0;
    wait_writes(5, "backpressure");
    for (int k = 0; k < 5; k++)
      check_write(k, 32'h200 + 32'(4 * k), 32'h20010000 | 32'(k + 1), "backpressure");
  endtask

  task automatic test_illegal();
    do_reset();
    imem_ack_i = 1'b1;
    do_start(32'h300);
    send(4'd2, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal err before: got %b want 0", err_o);
    end
    send(4'd12, 5'd7, 5'd7, 5'd7, 6'd7, 16'h7777);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal err set: got %b want 1", err_o);
    end
    send(4'd4, 5'd4, 5'd5, 5'd31, 6'h3F, 16'h0008);
    wait_writes(2, "illegal");
    repeat (8) tick();
    checks++;
    if (wr_q.size() != 2 || err_o !== 1'b1 || count_o !== 8'd2) begin
      errors++;
      $display("FAIL illegal end: got writes=%0d err=%b count=%0d want 2 1 2",
               wr_q.size(), err_o, count_o);
    end
    check_write(0, 32'h300, 32'h28430010, "illegal");
    check_write(1, 32'h304, 32'hAC850008, "illegal");
  endtask

  task automatic test_prestart();
    do_reset();
    imem_ack_i = 1'b1;
    send(4'd6, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0003);
    send(4'd8, 5'd3, 5'd4, 5'd0, 6'd0, 16'h8000);
    repeat (4) tick();
    checks++;
    if (imem_we_o !== 1'b0 || busy_o !== 1'b1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL prestart idle: got we=%b busy=%b writes=%0d want 0 1 0",
               imem_we_o, busy_o, wr_q.size());
    end
    do_start(32'hFFFFFFFC);
    wait_writes(2, "prestart");
    check_write(0, 32'hFFFFFFFC, 32'h14220003, "prestart");
    check_write(1, 32'h00000000, 32'h1C648000, "prestart");
  endtask

  task automatic test_reset_mid_write();
    int budget;
    do_reset();
    imem_ack_i = 1'b0;
    do_start(32'h400);
    send(4'd13, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000);
    send(4'd7, 5'd6, 5'd6, 5'd0, 6'd0, 16'h1234);
    budget = 10;
    while (!imem_we_o && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (imem_we_o !== 1'b1 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL midwrite setup: got we=%b err=%b want 1 1", imem_we_o, err_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({imem_we_o, imem_addr_o, imem_data_o, count_o, err_o, busy_o, req_ready_o} !== 76'd1) begin
      errors++;
      $display("FAIL midwrite reset: got we=%b addr=%h data=%h cnt=%0d err=%b busy=%b ready=%b want 0s ready=1",
               imem_we_o, imem_addr_o, imem_data_o, count_o, err_o, busy_o, req_ready_o);
    end
    tick();
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    tick();
    do_start(32'h500);
    repeat (10) tick();
    checks++;
    if (wr_q.size() != 0 || imem_we_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midwrite after release: got writes=%0d we=%b busy=%b want 0 0 0",
               wr_q.size(), imem_we_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_illegal();
    test_prestart();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk_i and rst_i as elsewhere in the codebase.
REQ-002 clk_i  input  1  clock, all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  arm the write engine; loads the address counter.
REQ-005 base_addr_i  input  32  first instruction-memory byte address, sampled when start_i is accepted.
REQ-006 req_valid_i  input  1  an instruction request is present.
REQ-007 req_ready_o  output  1  the block can accept a request this cycle.
REQ-008 req_class_i  input  4  instruction class: 0=R, 1=addi, 2=slti, 3=beq, 4=sw, 5=lw, 6=bne, 7=bge, 8=bgt.
REQ-009 req_rs_i, req_rt_i, req_rd_i  input  5 each  register fields.
REQ-010 req_funct_i  input  6  R-type funct field.
REQ-011 req_imm_i  input  16  immediate or branch offset.
REQ-012 imem_we_o  output  1  instruction-memory write strobe.
REQ-013 imem_addr_o  output  32  write byte address.
REQ-014 imem_data_o  output  32  encoded instruction word.
REQ-015 imem_ack_i  input  1  memory accepted the current write.
REQ-016 count_o  output  8  number of words written since the last start.
REQ-017 err_o  output  1  sticky illegal-class flag.
REQ-018 busy_o  output  1  asserted when the FIFO is non-empty or a write is pending.

Function
REQ-019 Opcodes SHALL be: R=0, addi=8, slti=10, beq=4, sw=43, lw=35, bne=5, bge=1, bgt=7.
REQ-020 R-type words SHALL be {6'd0, rs, rt, rd, 5'd0, funct}.
REQ-021 All other legal classes SHALL encode as {opcode, rs, rt, imm}, with rd and funct ignored.
REQ-022 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both high.
REQ-023 req_ready_o SHALL equal "FIFO not full"; it is independent of FSM state and of req_valid_i.
REQ-024 An accepted legal request SHALL push its encoded word into a 4-entry FIFO on the same edge.
REQ-025 An accepted class greater than 8 SHALL push nothing and SHALL set err_o, which holds until reset.
REQ-026 A push and a pop on the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-027 No push SHALL occur while the FIFO is full.
REQ-028 The FSM SHALL have three states: IDLE, ARMED and WRITE.
REQ-029 In IDLE, start_i=1 SHALL load addr=base_addr_i and count=0, then move to ARMED.
REQ-030 start_i SHALL be ignored in ARMED and in WRITE.
REQ-031 In ARMED with the FIFO non-empty, the FSM SHALL move to WRITE; with the FIFO empty it SHALL stay in ARMED.
REQ-032 In WRITE, imem_we_o SHALL be 1, imem_data_o SHALL equal the FIFO head, and imem_addr_o SHALL equal addr.
REQ-033 In WRITE, all three imem outputs SHALL hold steady until imem_ack_i=1.
REQ-034 On the edge where WRITE sees imem_ack_i=1, the block SHALL pop the FIFO, set addr+=4 (mod 2^32), set count+=1 (saturating at 255), and return to ARMED.
REQ-035 imem_we_o SHALL be 0 in IDLE and in ARMED.
REQ-036 Latency: with the FSM in ARMED and the FIFO empty, a word accepted at edge N SHALL appear with imem_we_o=1 in the cycle after edge N+1.
REQ-037 Back-to-back writes SHALL have a one-cycle ARMED bubble between them.
REQ-038 Requests accepted while in IDLE SHALL queue in the FIFO and be written only after start_i.
REQ-039 busy_o SHALL be (FIFO non-empty) OR (state==WRITE).

Reset
REQ-040 On rst_i=0, the block SHALL asynchronously enter IDLE, empty the FIFO, and clear addr, count_o, err_o, imem_we_o, imem_addr_o, imem_data_o and busy_o to 0.
REQ-041 After reset, req_ready_o SHALL be 1.
REQ-042 A reset during WRITE SHALL abandon the write, and the word SHALL NOT be written after reset release.

Verification
REQ-043 Single encodes: start with base=0x100, ack tied to 1, send four requests, and check the memory writes:
- addi rs=0 rt=9 imm=5 -> 0x20090005 @0x100
- R rs=8 rt=9 rd=10 funct=0x20 -> 0x01095020 @0x104
- lw rs=29 rt=8 imm=4 -> 0x8FA80004 @0x108
- beq rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF @0x10C
- count_o=4 at the end.
REQ-044 Backpressure: hold imem_ack_i=0 and push 5 requests -> req_ready_o falls after the 4th; all outputs are stable during the stall; releasing ack drains the words in order.
REQ-045 Illegal class: send class=12 between two legal requests -> err_o=1 stays set, only 2 writes occur, and addresses stay contiguous.
REQ-046 Pre-start queueing: send 2 requests in IDLE -> no imem_we_o and busy_o=1; start_i with base=0xFFFFFFFC -> writes go to 0xFFFFFFFC then 0x00000000.
REQ-047 Reset mid-write: assert rst_i=0 while in WRITE -> all outputs become 0 immediately and req_ready_o=1; after release, with no new requests, no write occurs.
